reg_file_write_arbiter: RTL and testbench
=========================================

// Module: reg_file_write_arbiter
// PURPOSE
//   Shares the single write port of reg_file (IN/INADDRESS/WRITE) between two
//   requesters, e.g. the CPU writeback path and a debug/loader path, using
//   round-robin arbitration with a REQ/GNT handshake.
//   Also provides a clear sequencer that writes CLR_VALUE to every register,
//   one per cycle.
//   Sits between the requesters and reg_file. The read ports are not touched.
// PARAMETERS
//   DATA_W     8    register data width; must match reg_file
//   ADDR_W     3    register address width
//   DEPTH      8    number of registers swept by a clear; equals 2**ADDR_W
//   CLR_VALUE  8'h00  value written to each register during a clear
// PORTS
//   CLK        in   1       clock; all state updates on posedge
//   RESET      in   1       synchronous, active-low reset (0 = reset at posedge CLK)
//   REQ0       in   1       requester 0 write request (level)
//   ADDR0      in   ADDR_W  requester 0 target register
//   DATA0      in   DATA_W  requester 0 write data
//   GNT0       out  1       requester 0 grant; one-cycle pulse
//   REQ1       in   1       requester 1 write request (level)
//   ADDR1      in   ADDR_W  requester 1 target register
//   DATA1      in   DATA_W  requester 1 write data
//   GNT1       out  1       requester 1 grant; one-cycle pulse
//   CLR_START  in   1       start a clear sweep; sampled only in IDLE
//   BUSY       out  1       high while a clear sweep is issuing writes
//   CLR_DONE   out  1       one-cycle pulse when a sweep completes
//   IN         out  DATA_W  to reg_file IN
//   INADDRESS  out  ADDR_W  to reg_file INADDRESS
//   WRITE      out  1       to reg_file WRITE; reg_file commits on the next posedge
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (RESET==0 at posedge): all outputs 0, state IDLE, clear counter 0,
//     rr pointer LAST=1, so requester 0 wins the first tie.
//   - Reset overrides everything, including a sweep in progress. The sweep is
//     abandoned and is not resumed.
//   - Idle cycle: WRITE=0, GNT0=GNT1=0. IN/INADDRESS hold their last values
//     (don't-care while WRITE=0).
//   - FSM states: IDLE, CLEAR.
//   - IDLE, posedge k:
//     - If CLR_START==1, go to CLEAR. It beats any pending REQ, and no grant
//       is given at this edge.
//     - Otherwise arbitrate:
//       - Requester i is eligible if REQi==1 and GNTi==0 at the edge. A
//         request whose grant is currently high counts as consumed.
//       - One eligible requester: it wins.
//       - Both eligible: the requester != LAST wins.
//       - Winner w: at edge k set GNTw=1, WRITE=1, INADDRESS=ADDRw,
//         IN=DATAw, LAST=w.
//       - reg_file updates at edge k+1 (request-to-commit latency 1 cycle).
//   - Handshake:
//     - Requester holds REQ/ADDR/DATA stable until it samples GNT==1.
//     - At that edge it may drop REQ or present the next payload.
//     - Consequences: a lone requester gets at most 1 write per 2 cycles.
//       Two contending requesters alternate 0,1,0,1 at full rate.
//   - CLEAR:
//     - Entered at edge k with cnt=0. The same edge issues WRITE=1,
//       INADDRESS=0, IN=CLR_VALUE, BUSY=1.
//     - Edges k+1..k+DEPTH-1 issue addresses 1..DEPTH-1. BUSY stays 1.
//     - Edge k+DEPTH: WRITE=0, BUSY=0, CLR_DONE=1 for one cycle, state IDLE.
//       Normal arbitration applies at this same edge, so a request held
//       through the sweep can be granted here with WRITE=1.
//     - GNT0/GNT1 are 0 throughout edges k..k+DEPTH-1.
//     - REQs are not lost; they stay pending.
//     - CLR_START is ignored while in CLEAR.
//   - Widths: the address counter is ADDR_W+1 bits to detect the end of the
//     sweep. INADDRESS is its low ADDR_W bits. No arithmetic on data.
//   - Invariants:
//     - WRITE == GNT0|GNT1|BUSY.
//     - GNT0 & GNT1 is never 1.
// TESTING
//   1. Hold RESET=0 for 2 edges with REQ0=REQ1=CLR_START=1.
//      -> all outputs 0; no write reaches reg_file.
//   2. REQ0=1, ADDR0=3, DATA0=8'hA5, alone.
//      -> next edge: GNT0=1, WRITE=1, INADDRESS=3, IN=A5 for 1 cycle.
//      -> reg 3 reads A5 after the following edge.
//   3. REQ0 and REQ1 held high, payloads changed on each grant.
//      -> grants alternate 0,1,0,1, requester 0 first after reset.
//      -> WRITE is high every cycle; no double grant.
//   4. Preload regs with 8'h11..8'h88, pulse CLR_START, hold REQ1 (ADDR1=5,
//      DATA1=8'h5A) from the same cycle.
//      -> 8 writes to addresses 0..7 with value 0; BUSY high 8 cycles.
//      -> then CLR_DONE pulses together with GNT1; final reg5=5A, others 0.
//   5. Start a clear, assert RESET=0 after 3 writes.
//      -> outputs 0 at that edge; regs 3..7 keep their preload values.
//      -> CLR_DONE never pulses.
//   6. REQ0 held high alone for 10 cycles.
//      -> GNT0 pulses on every other cycle (5 grants); WRITE matches GNT0.

Source files
------------

// File: rtl/reg_file_write_arbiter.sv
// Round-robin arbiter for the single reg_file write port, shared by two REQ/GNT
// requesters, plus a clear sequencer that sweeps CLR_VALUE over every register.
module reg_file_write_arbiter #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 3,
  parameter int                DEPTH     = 8,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] DATA0,
  output logic              GNT0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              GNT1,
  input  logic              CLR_START,
  output logic              BUSY,
  output logic              CLR_DONE,
  output logic [DATA_W-1:0] IN,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic              WRITE
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0] END_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state, state_n;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic              last, last_n;
  logic              gnt0_n, gnt1_n, busy_n, done_n, write_n;
  logic [DATA_W-1:0] in_n;
  logic [ADDR_W-1:0] addr_n;
  logic              elig0, elig1, win0, win1;

  // A request whose grant is currently high has already been serviced.
  assign elig0 = REQ0 & ~GNT0;
  assign elig1 = REQ1 & ~GNT1;
  assign win0  = elig0 & (~elig1 | last);
  assign win1  = elig1 & (~elig0 | ~last);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      BUSY      <= 1'b0;
      CLR_DONE  <= 1'b0;
      WRITE     <= 1'b0;
      IN        <= '0;
      INADDRESS <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last      <= last_n;
      GNT0      <= gnt0_n;
      GNT1      <= gnt1_n;
      BUSY      <= busy_n;
      CLR_DONE  <= done_n;
      WRITE     <= write_n;
      IN        <= in_n;
      INADDRESS <= addr_n;
    end
  end

  // cnt holds the next sweep address; reaching DEPTH ends the sweep.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    gnt0_n  = 1'b0;
    gnt1_n  = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    write_n = 1'b0;
    in_n    = IN;
    addr_n  = INADDRESS;

    if (state == IDLE && CLR_START) begin
      state_n = CLEAR;
      cnt_n   = (ADDR_W+1)'(1);
      write_n = 1'b1;
      busy_n  = 1'b1;
      addr_n  = '0;
      in_n    = CLR_VALUE;
    end else if (state == CLEAR && cnt != END_CNT) begin
      cnt_n   = cnt + (ADDR_W+1)'(1);
      write_n = 1'b1;
      busy_n  = 1'b1;
      addr_n  = cnt[ADDR_W-1:0];
      in_n    = CLR_VALUE;
    end else begin
      if (state == CLEAR) begin
        state_n = IDLE;
        cnt_n   = '0;
        done_n  = 1'b1;
      end
      if (win0) begin
        gnt0_n  = 1'b1;
        write_n = 1'b1;
        addr_n  = ADDR0;
        in_n    = DATA0;
        last_n  = 1'b0;
      end else if (win1) begin
        gnt1_n  = 1'b1;
        write_n = 1'b1;
        addr_n  = ADDR1;
        in_n    = DATA1;
        last_n  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Self-checking bench for reg_file_write_arbiter: a scoreboard of expected
// writes plus a behavioural reg_file fed by the write port.
module tb_reg_file_write_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, CLR_START = 1'b0;
  logic [2:0] ADDR0 = '0, ADDR1 = '0;
  logic [7:0] DATA0 = '0, DATA1 = '0;
  logic       GNT0, GNT1, BUSY, CLR_DONE, WRITE;
  logic [7:0] IN;
  logic [2:0] INADDRESS;

  typedef struct packed {
    logic [1:0] src;
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] regs_m [8];
  int         checks = 0;
  int         errors = 0;

  reg_file_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0), .GNT0(GNT0),
    .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1), .GNT1(GNT1),
    .CLR_START(CLR_START), .BUSY(BUSY), .CLR_DONE(CLR_DONE),
    .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t mk(input logic [1:0] src, input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    e.src = src; e.addr = a; e.data = d;
    return e;
  endfunction

  // Advance one edge, then check invariants and retire any write against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    checks++;
    if (WRITE !== (GNT0 | GNT1 | BUSY) || (GNT0 & GNT1) !== 1'b0) begin
      errors++;
      $display("[TB] FAIL invariant: WRITE=%b GNT0=%b GNT1=%b BUSY=%b", WRITE, GNT0, GNT1, BUSY);
    end
    if (WRITE === 1'b1) begin
      regs_m[INADDRESS] = IN;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: addr=%0d data=%h, none required", INADDRESS, IN);
      end else begin
        e = exp_q.pop_front();
        if ({GNT0, GNT1, BUSY, INADDRESS, IN} !==
            {e.src == 2'd0, e.src == 2'd1, e.src == 2'd2, e.addr, e.data}) begin
          errors++;
          $display("[TB] FAIL write: got g0=%b g1=%b busy=%b addr=%0d data=%h, required src=%0d addr=%0d data=%h",
                   GNT0, GNT1, BUSY, INADDRESS, IN, e.src, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  task automatic preload();
    for (int a = 0; a < 8; a++) begin
      ADDR0 = a[2:0];
      DATA0 = 8'(8'h11 * (a + 1));
      exp_q.push_back(mk(2'd0, ADDR0, DATA0));
      REQ0 = 1'b1;
      tick();
      checks++;
      if (GNT0 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL preload_gnt: GNT0=%b required 1", GNT0);
      end
      REQ0 = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; CLR_START = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({GNT0, GNT1, BUSY, CLR_DONE, WRITE, IN, INADDRESS} !== 16'h0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got %h required 0",
                 {GNT0, GNT1, BUSY, CLR_DONE, WRITE, IN, INADDRESS});
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0; CLR_START = 1'b0; RESET = 1'b1;
    tick();
  endtask

  task automatic test_single();
    REQ0 = 1'b1; ADDR0 = 3'd3; DATA0 = 8'hA5;
    exp_q.push_back(mk(2'd0, 3'd3, 8'hA5));
    tick();
    checks++;
    if ({GNT0, WRITE, INADDRESS, IN} !== {1'b1, 1'b1, 3'd3, 8'hA5}) begin
      errors++;
      $display("[TB] FAIL single_grant: got g0=%b w=%b addr=%0d data=%h", GNT0, WRITE, INADDRESS, IN);
    end
    REQ0 = 1'b0;
    tick();
    checks++;
    if ({GNT0, WRITE} !== 2'b00 || regs_m[3] !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_after: g0=%b w=%b reg3=%h required 0 0 a5", GNT0, WRITE, regs_m[3]);
    end
  endtask

  task automatic test_round_robin();
    int n0 = 0, n1 = 0;
    do_reset();
    ADDR0 = 3'd0; DATA0 = 8'h20; ADDR1 = 3'd4; DATA1 = 8'h40;
    exp_q.push_back(mk(2'd0, ADDR0, DATA0));
    exp_q.push_back(mk(2'd1, ADDR1, DATA1));
    REQ0 = 1'b1; REQ1 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if ({GNT0, GNT1, WRITE} !== {n % 2 == 0, n % 2 == 1, 1'b1}) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: got g0=%b g1=%b w=%b", n, GNT0, GNT1, WRITE);
      end
      if (GNT0 === 1'b1) begin
        n0++;
        if (n < 6) begin
          ADDR0 = 3'(n0); DATA0 = 8'(8'h20 + n0);
          exp_q.push_back(mk(2'd0, ADDR0, DATA0));
        end else REQ0 = 1'b0;
      end
      if (GNT1 === 1'b1) begin
        n1++;
        if (n < 6) begin
          ADDR1 = 3'(4 + n1); DATA1 = 8'(8'h40 + n1);
          exp_q.push_back(mk(2'd1, ADDR1, DATA1));
        end else REQ1 = 1'b0;
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    checks++;
    if (WRITE !== 1'b0 || n0 != 4 || n1 != 4) begin
      errors++;
      $display("[TB] FAIL rr_end: w=%b grants0=%0d grants1=%0d required 0 4 4", WRITE, n0, n1);
    end
  endtask

  task automatic test_clear_with_req();
    preload();
    CLR_START = 1'b1;
    REQ1 = 1'b1; ADDR1 = 3'd5; DATA1 = 8'h5A;
    for (int a = 0; a < 8; a++) exp_q.push_back(mk(2'd2, a[2:0], 8'h00));
    exp_q.push_back(mk(2'd1, 3'd5, 8'h5A));
    for (int c = 0; c < 8; c++) begin
      tick();
      CLR_START = 1'b0;
      checks++;
      if ({BUSY, CLR_DONE, GNT1} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL clear_busy[%0d]: busy=%b done=%b g1=%b required 1 0 0", c, BUSY, CLR_DONE, GNT1);
      end
    end
    tick();
    checks++;
    if ({BUSY, CLR_DONE, GNT1, WRITE} !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL clear_done: busy=%b done=%b g1=%b w=%b required 0 1 1 1", BUSY, CLR_DONE, GNT1, WRITE);
    end
    REQ1 = 1'b0;
    tick();
    checks++;
    if ({CLR_DONE, WRITE} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL clear_after: done=%b w=%b required 0 0", CLR_DONE, WRITE);
    end
    for (int a = 0; a < 8; a++) begin
      checks++;
      if (regs_m[a] !== ((a == 5) ? 8'h5A : 8'h00)) begin
        errors++;
        $display("[TB] FAIL clear_reg[%0d]: got %h", a, regs_m[a]);
      end
    end
  endtask

  task automatic test_clear_reset();
    logic seen_done = 1'b0;
    preload();
    CLR_START = 1'b1;
    for (int a = 0; a < 3; a++) exp_q.push_back(mk(2'd2, a[2:0], 8'h00));
    for (int c = 0; c < 3; c++) begin
      tick();
      CLR_START = 1'b0;
    end
    RESET = 1'b0;
    tick();
    checks++;
    if ({GNT0, GNT1, BUSY, CLR_DONE, WRITE, IN, INADDRESS} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got %h required 0",
               {GNT0, GNT1, BUSY, CLR_DONE, WRITE, IN, INADDRESS});
    end
    RESET = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (CLR_DONE === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_done: CLR_DONE pulsed, required never");
    end
    for (int a = 0; a < 8; a++) begin
      checks++;
      if (regs_m[a] !== ((a < 3) ? 8'h00 : 8'(8'h11 * (a + 1)))) begin
        errors++;
        $display("[TB] FAIL abort_reg[%0d]: got %h", a, regs_m[a]);
      end
    end
  endtask

  task automatic test_lone_rate();
    int grants = 0;
    REQ0 = 1'b1; ADDR0 = 3'd6; DATA0 = 8'hC3;
    for (int g = 0; g < 5; g++) exp_q.push_back(mk(2'd0, 3'd6, 8'hC3));
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if ({GNT0, WRITE} !== {2{j % 2 == 0}}) begin
        errors++;
        $display("[TB] FAIL lone_cycle[%0d]: g0=%b w=%b required %0d", j, GNT0, WRITE, j % 2 == 0);
      end
      if (GNT0 === 1'b1) grants++;
    end
    REQ0 = 1'b0;
    tick();
    checks++;
    if (grants != 5 || WRITE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lone_count: grants=%0d w=%b required 5 0", grants, WRITE);
    end
  endtask

  initial begin
    for (int a = 0; a < 8; a++) regs_m[a] = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_clear_with_req();
    test_clear_reset();
    test_lone_rate();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
